// File: rtl/mem_order_matrix.sv
// Load/store ordering matrix: tracks which unresolved older stores each queued load waits on,
// and reports per-entry load readiness to the memory select logic.
module mem_order_matrix #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_we0,
    input  logic [IDX_W-1:0] disp_idx0,
    input  logic [1:0]       disp_type0,
    input  logic             disp_we1,
    input  logic [IDX_W-1:0] disp_idx1,
    input  logic [1:0]       disp_type1,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic [DEPTH-1:0] dealloc,
    input  logic             flush,
    output logic [DEPTH-1:0] entry_valid,
    output logic [DEPTH-1:0] ld_ready,
    output logic [DEPTH-1:0] store_unres,
    output logic             disp_err
);

    typedef enum logic [1:0] {
        MT_NONE  = 2'b00,
        MT_LOAD  = 2'b01,
        MT_STORE = 2'b10,
        MT_OTHER = 2'b11
    } mem_type_e;

    logic [DEPTH-1:0]            valid_q, valid_n;
    logic [DEPTH-1:0]            unres_q, unres_n;
    mem_type_e                   typ_q [DEPTH];
    mem_type_e                   typ_n [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] dep_q, dep_n;
    logic                        err_q, err_n;

    logic [DEPTH-1:0] su_now;
    logic             ok0, ok1, clash;
    mem_type_e        t0, t1;

    always_comb begin
        valid_n = valid_q;
        unres_n = unres_q;
        typ_n   = typ_q;
        dep_n   = dep_q;
        err_n   = 1'b0;
        su_now  = '0;
        ok0     = 1'b0;
        ok1     = 1'b0;
        clash   = 1'b0;
        t0      = mem_type_e'(disp_type0);
        t1      = mem_type_e'(disp_type1);

        if (flush) begin
            valid_n = '0;
            unres_n = '0;
            dep_n   = '0;
        end else begin
            valid_n = valid_q & ~dealloc;
            unres_n = unres_q & ~dealloc;
            for (int unsigned r = 0; r < DEPTH; r++) begin
                dep_n[r] = dealloc[r] ? '0 : (dep_q[r] & ~dealloc);
            end

            if (res_valid && valid_n[res_idx] && typ_q[res_idx] == MT_STORE) begin
                unres_n[res_idx] = 1'b0;
                for (int unsigned r = 0; r < DEPTH; r++) begin
                    dep_n[r][res_idx] = 1'b0;
                end
            end

            // Loads dispatched now wait only on stores still unresolved after dealloc/resolve.
            su_now = valid_n & unres_n;

            clash = disp_we0 && disp_we1 && (disp_idx0 == disp_idx1);
            ok0   = disp_we0 && !valid_n[disp_idx0];
            ok1   = disp_we1 && !clash && !valid_n[disp_idx1];
            err_n = (disp_we0 && !ok0) || (disp_we1 && !ok1);

            if (ok0) begin
                valid_n[disp_idx0] = 1'b1;
                typ_n[disp_idx0]   = t0;
                unres_n[disp_idx0] = (t0 == MT_STORE);
                dep_n[disp_idx0]   = (t0 == MT_LOAD) ? su_now : '0;
                for (int unsigned r = 0; r < DEPTH; r++) begin
                    dep_n[r][disp_idx0] = 1'b0;
                end
            end

            if (ok1) begin
                valid_n[disp_idx1] = 1'b1;
                typ_n[disp_idx1]   = t1;
                unres_n[disp_idx1] = (t1 == MT_STORE);
                dep_n[disp_idx1]   = (t1 == MT_LOAD) ? su_now : '0;
                for (int unsigned r = 0; r < DEPTH; r++) begin
                    dep_n[r][disp_idx1] = 1'b0;
                end
                // Port 0 is older: a load on port 1 waits on a store written by port 0.
                if (ok0 && t0 == MT_STORE && t1 == MT_LOAD) begin
                    dep_n[disp_idx1][disp_idx0] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            unres_q <= '0;
            dep_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                typ_q[i] <= MT_NONE;
            end
        end else begin
            valid_q <= valid_n;
            unres_q <= unres_n;
            dep_q   <= dep_n;
            err_q   <= err_n;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                typ_q[i] <= typ_n[i];
            end
        end
    end

    always_comb begin
        ld_ready = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ld_ready[i] = valid_q[i] && (typ_q[i] == MT_LOAD) && (dep_q[i] == '0);
        end
    end

    assign entry_valid = valid_q;
    assign store_unres = valid_q & unres_q;
    assign disp_err    = err_q;

endmodule

// File: tb/tb_mem_order_matrix.sv
// Bench for mem_order_matrix: directed vector table followed by random traffic
// checked against a store-identity based reference model.
module tb_mem_order_matrix;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_we0, disp_we1, res_valid, flush;
    logic [2:0] disp_idx0, disp_idx1, res_idx;
    logic [1:0] disp_type0, disp_type1;
    logic [7:0] dealloc;
    logic [7:0] entry_valid, ld_ready, store_unres;
    logic       disp_err;

    int checks = 0;
    int errors = 0;

    mem_order_matrix #(.DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .disp_we0(disp_we0), .disp_idx0(disp_idx0), .disp_type0(disp_type0),
        .disp_we1(disp_we1), .disp_idx1(disp_idx1), .disp_type1(disp_type1),
        .res_valid(res_valid), .res_idx(res_idx), .dealloc(dealloc), .flush(flush),
        .entry_valid(entry_valid), .ld_ready(ld_ready), .store_unres(store_unres),
        .disp_err(disp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         we0; logic [2:0] i0; logic [1:0] t0;
        bit         we1; logic [2:0] i1; logic [1:0] t1;
        bit         rv;  logic [2:0] ri;
        logic [7:0] da;  bit fl;
        logic [7:0] ev, lr, su; bit er;
    } vec_t;

    function automatic vec_t mk(bit r, bit w0, int i0, int t0, bit w1, int i1, int t1,
                                bit rv, int ri, int da, bit fl, int ev, int lr, int su, bit er);
        vec_t v;
        v.rst = r; v.we0 = w0; v.i0 = 3'(i0); v.t0 = 2'(t0);
        v.we1 = w1; v.i1 = 3'(i1); v.t1 = 2'(t1);
        v.rv = rv; v.ri = 3'(ri); v.da = 8'(da); v.fl = fl;
        v.ev = 8'(ev); v.lr = 8'(lr); v.su = 8'(su); v.er = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit w0, input logic [2:0] i0, input logic [1:0] t0,
                         input bit w1, input logic [2:0] i1, input logic [1:0] t1,
                         input bit rv, input logic [2:0] ri, input logic [7:0] da, input bit fl);
        rst = r; disp_we0 = w0; disp_idx0 = i0; disp_type0 = t0;
        disp_we1 = w1; disp_idx1 = i1; disp_type1 = t1;
        res_valid = rv; res_idx = ri; dealloc = da; flush = fl;
    endtask

    // Reference model: every dispatch gets a unique id; a load remembers the ids of the
    // stores that were pending when it entered, and is ready once none is still pending.
    bit          m_valid [D];
    logic [1:0]  m_type  [D];
    bit          m_unres [D];
    int unsigned m_id    [D];
    int unsigned m_wait  [D][$];
    int unsigned next_id = 1;
    bit          m_err;

    function automatic bit id_pending(int unsigned id);
        for (int j = 0; j < D; j++)
            if (m_valid[j] && m_unres[j] && m_id[j] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int unsigned pend[$];
        bit ok0, ok1;
        if (!rst || flush) begin
            for (int i = 0; i < D; i++) begin
                m_valid[i] = 0; m_unres[i] = 0; m_wait[i].delete();
                if (!rst) m_type[i] = 2'b00;
            end
            m_err = 0;
            return;
        end
        for (int i = 0; i < D; i++)
            if (dealloc[i]) begin m_valid[i] = 0; m_unres[i] = 0; end
        if (res_valid && m_valid[res_idx] && m_type[res_idx] == 2'b10) m_unres[res_idx] = 0;
        for (int j = 0; j < D; j++)
            if (m_valid[j] && m_unres[j]) pend.push_back(m_id[j]);
        ok0 = disp_we0 && !m_valid[disp_idx0];
        ok1 = disp_we1 && !(disp_we0 && disp_idx0 == disp_idx1) && !m_valid[disp_idx1];
        m_err = (disp_we0 && !ok0) || (disp_we1 && !ok1);
        if (ok0) begin
            m_valid[disp_idx0] = 1; m_type[disp_idx0] = disp_type0;
            m_unres[disp_idx0] = (disp_type0 == 2'b10);
            m_id[disp_idx0] = next_id++;
            m_wait[disp_idx0].delete();
            if (disp_type0 == 2'b01) m_wait[disp_idx0] = pend;
        end
        if (ok1) begin
            m_valid[disp_idx1] = 1; m_type[disp_idx1] = disp_type1;
            m_unres[disp_idx1] = (disp_type1 == 2'b10);
            m_id[disp_idx1] = next_id++;
            m_wait[disp_idx1].delete();
            if (disp_type1 == 2'b01) begin
                m_wait[disp_idx1] = pend;
                if (ok0 && disp_type0 == 2'b10) m_wait[disp_idx1].push_back(m_id[disp_idx0]);
            end
        end
    endtask

    function automatic logic [7:0] m_ev();
        logic [7:0] v = '0;
        for (int i = 0; i < D; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [7:0] m_su();
        logic [7:0] v = '0;
        for (int i = 0; i < D; i++) v[i] = m_valid[i] && m_unres[i];
        return v;
    endfunction

    function automatic logic [7:0] m_lr();
        logic [7:0] v = '0;
        for (int i = 0; i < D; i++) begin
            v[i] = m_valid[i] && m_type[i] == 2'b01;
            foreach (m_wait[i][k]) if (id_pending(m_wait[i][k])) v[i] = 1'b0;
        end
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);

        //            rst w0 i0 t0 w1 i1 t1 rv ri dealloc fl  ev    lr    su    er
        tbl.push_back(mk(0, 1, 1, 1, 1, 3, 2, 1, 2, 8'h5A, 0, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 1, 2, 2, 0, 0, 0, 0, 0, 8'h00, 0, 8'h04, 8'h00, 8'h04, 0));
        tbl.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h24, 8'h00, 8'h04, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 8'h00, 0, 8'h24, 8'h20, 8'h00, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h24, 0, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 1, 0, 2, 1, 1, 1, 0, 0, 8'h00, 0, 8'h03, 8'h00, 8'h01, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h03, 8'h00, 8'h01, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 0, 8'h02, 8'h02, 8'h00, 0));
        tbl.push_back(mk(1, 1, 3, 2, 0, 0, 0, 0, 0, 8'h02, 0, 8'h08, 8'h00, 8'h08, 0));
        tbl.push_back(mk(1, 1, 4, 1, 0, 0, 0, 1, 3, 8'h00, 0, 8'h18, 8'h10, 8'h00, 0));
        tbl.push_back(mk(1, 1, 6, 1, 0, 0, 0, 0, 0, 8'h18, 0, 8'h40, 8'h40, 8'h00, 0));
        tbl.push_back(mk(1, 1, 6, 2, 0, 0, 0, 0, 0, 8'h00, 0, 8'h40, 8'h40, 8'h00, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h40, 8'h40, 8'h00, 0));
        tbl.push_back(mk(1, 1, 7, 2, 1, 7, 1, 0, 0, 8'h00, 0, 8'hC0, 8'h40, 8'h80, 1));
        tbl.push_back(mk(1, 1, 0, 3, 1, 1, 0, 0, 0, 8'h00, 0, 8'hC3, 8'h40, 8'h80, 0));
        tbl.push_back(mk(1, 1, 2, 0, 1, 3, 3, 0, 0, 8'h00, 0, 8'hCF, 8'h40, 8'h80, 0));
        tbl.push_back(mk(1, 1, 4, 1, 1, 5, 1, 0, 0, 8'h00, 0, 8'hFF, 8'h40, 8'h80, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 3, 2, 1, 7, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 1, 0, 2, 1, 1, 2, 0, 0, 8'h00, 0, 8'h03, 8'h00, 8'h03, 0));
        tbl.push_back(mk(1, 1, 2, 0, 1, 3, 1, 0, 0, 8'h00, 0, 8'h0F, 8'h00, 8'h03, 0));
        tbl.push_back(mk(1, 1, 4, 3, 1, 5, 0, 0, 0, 8'h00, 0, 8'h3F, 8'h00, 8'h03, 0));
        tbl.push_back(mk(1, 1, 6, 0, 1, 7, 1, 0, 0, 8'h00, 0, 8'hFF, 8'h00, 8'h03, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 8'h01, 0, 8'hFF, 8'h00, 8'h02, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0, 8'hFF, 8'h89, 8'h00, 0));
        tbl.push_back(mk(1, 1, 5, 2, 0, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 8'h89, 8'h00, 1));

        @(posedge clk); #1;
        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].rst, tbl[n].we0, tbl[n].i0, tbl[n].t0, tbl[n].we1, tbl[n].i1,
                  tbl[n].t1, tbl[n].rv, tbl[n].ri, tbl[n].da, tbl[n].fl);
            @(posedge clk); #1;
            check($sformatf("vec%0d entry_valid", n), entry_valid, tbl[n].ev);
            check($sformatf("vec%0d ld_ready", n), ld_ready, tbl[n].lr);
            check($sformatf("vec%0d store_unres", n), store_unres, tbl[n].su);
            check($sformatf("vec%0d disp_err", n), {7'b0, disp_err}, {7'b0, tbl[n].er});
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        model_step();
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] da;
            da = '0;
            for (int b = 0; b < D; b++) da[b] = ($urandom_range(0, 11) == 0);
            drive($urandom_range(0, 199) != 0,
                  $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), da,
                  $urandom_range(0, 99) == 0);
            model_step();
            @(posedge clk); #1;
            check("rand entry_valid", entry_valid, m_ev());
            check("rand ld_ready", ld_ready, m_lr());
            check("rand store_unres", store_unres, m_su());
            check("rand disp_err", {7'b0, disp_err}, {7'b0, m_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
